mixcolumn_engine: RTL

- Iterative, handshaked AES MixColumns/InvMixColumns engine, parametrised in columns processed per cycle.
- Sits between the ShiftRows (encrypt) or InvShiftRows (decrypt) stage and AddRoundKey in the round datapath.
- Replaces the purely combinational column mixer with a latency-bounded, area-scalable unit.
- Adds inverse mode and bypass mode (for the final round).

---
 rtl/mixcolumn_engine.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mixcolumn_engine.sv
// Iterative AES MixColumns / InvMixColumns engine with valid/ready handshakes.
// Mixes COLS_PER_CYCLE columns per cycle; bypass copies the state through with the same latency.
module mixcolumn_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv,
    input  logic         bypass,
    input  logic [127:0] shifted,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] mixed,
    output logic         busy
);

    localparam int N_ITER = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mixcolumn_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [127:0]  data_q;
    logic          inv_q, bypass_q;
    logic [127:0]  result_q, result_d;
    logic          accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Coefficients never exceed 0x0E, so four multiplier bits suffice.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col, input logic m_inv,
                                               input logic m_byp);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        if (m_byp) return col;
        if (m_inv)
            return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                    gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                    gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                    gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
        return {gmul(a0, 4'h2) ^ gmul(a1, 4'h3) ^ a2 ^ a3,
                a0 ^ gmul(a1, 4'h2) ^ gmul(a2, 4'h3) ^ a3,
                a0 ^ a1 ^ gmul(a2, 4'h2) ^ gmul(a3, 4'h3),
                gmul(a0, 4'h3) ^ a1 ^ a2 ^ gmul(a3, 4'h2)};
    endfunction

    assign accept = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: each combinational output gets a default first so no latch is inferred on unlisted paths.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_BUSY;
            S_BUSY: if (cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = accept ? S_BUSY : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // in_ready is forced low during reset and depends combinationally on out_ready in DONE.
    always_comb begin
        in_ready  = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_BUSY);
    end

    always_comb begin
        cnt_d    = cnt_q;
        result_d = result_q;
        if (accept) begin
            cnt_d = 2'd0;
        end else if (state_q == S_BUSY) begin
            cnt_d = cnt_q + CNT_STEP;
            for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                result_d[127 - 32 * (int'(cnt_q) + k) -: 32] =
                    mix_column(data_q[127 - 32 * (int'(cnt_q) + k) -: 32], inv_q, bypass_q);
            end
        end
    end

    // NOTE: the captured block is reset along with the result so a reset never exposes stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 2'd0;
            result_q <= 128'h0;
            data_q   <= 128'h0;
            inv_q    <= 1'b0;
            bypass_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            result_q <= result_d;
            if (accept) begin
                data_q   <= shifted;
                inv_q    <= inv;
                bypass_q <= bypass;
            end
        end
    end

    assign mixed = result_q;

endmodule
